imem_fetch_stage: RTL and testbench
===================================

Name: imem_fetch_stage

Overview:
Parametrised, writable instruction memory with a registered fetch stage and built-in field decode. Replaces the hardcoded combinational ROM. Programs are loaded at run time through a word-write port. Fetches are issued through a valid/ready handshake and return decoded fields one cycle later. It sits between the PC register and the register-file/ALU control.

Parameters:
ADDR_W, 6, word-address bits; memory depth = 2**ADDR_W words of 32 bits
REG_ADDR_W, 4, width of rs/rt/rd outputs (5-bit instruction fields truncated to the low REG_ADDR_W bits; legal range 1..5)
XLEN, 32, width of pc_in, imm_signed and jmp_signed

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  synchronous active-low reset
prog_we  in  1  program-load write enable
prog_addr  in  ADDR_W  word address for load
prog_data  in  32  instruction word to load
fetch_valid  in  1  fetch request valid
fetch_ready  out  1  fetch request accepted this cycle
pc_in  in  XLEN  byte address of fetch
flush  in  1  discard the in-flight/held fetch result (branch redirect)
out_valid  out  1  decoded result valid
out_ready  in  1  consumer accepts result
out_pc  out  XLEN  pc of returned instruction
instr  out  32  raw instruction word
opcode  out  6  instr[31:26]
funct  out  6  instr[5:0]
rs  out  REG_ADDR_W  instr[25:21] low bits
rt  out  REG_ADDR_W  instr[20:16] low bits
rd  out  REG_ADDR_W  instr[15:11] low bits
imm_signed  out  XLEN  instr[15:0] sign-extended
jmp_signed  out  XLEN  instr[25:0] zero-extended
fetch_err  out  1  returned word was forced to NOP (misaligned or out of range)

Behaviour:
- Reset (rst_n=0 at clk edge): out_valid=0, out_pc=0, instr=0, fetch_err=0. All decoded fields are therefore 0. Memory array is NOT cleared; it keeps its contents across reset.
- Memory write: if prog_we=1 at an edge, mem[prog_addr] <= prog_data. A write proceeds during reset.
- fetch_ready = rst_n & ~prog_we & ~flush & (~out_valid | out_ready). This is combinational; loads have priority over fetches, so a fetch never sees a same-cycle write.
- Accept = fetch_valid & fetch_ready. On an accept edge:
  - out_valid <= 1.
  - out_pc <= pc_in.
  - instr <= 0 with fetch_err <= 1 if pc_in[1:0] != 0, or if pc_in[XLEN-1:2] >= 2**ADDR_W.
  - Otherwise instr <= mem[pc_in[ADDR_W+1:2]] with fetch_err <= 0.
- Latency is exactly 1 cycle from accept to out_valid. Sustained throughput is 1 fetch/cycle while out_ready=1.
- Hold: while out_valid=1 and out_ready=0, out_pc, instr, fetch_err and all fields stay stable. No new accept occurs.
- Drain: if out_valid & out_ready and there is no accept, out_valid <= 0. Data registers keep their last value.
- Flush: flush=1 at an edge gives out_valid <= 0 regardless of out_ready. No accept occurs in that cycle. Flush has precedence over the hold.
- Read-after-write: a fetch accepted in the cycle after a write to the same word returns the new word.
- Decoded fields are pure combinational slices/extensions of the registered instr. rs/rt/rd take bits [REG_ADDR_W-1:0] of their 5-bit fields.
- Reset asserted mid-handshake: the held result is dropped (out_valid=0). fetch_ready=0 while rst_n=0.

Test Plan:
- Load/fetch: write mem[0]=0x00221801 (ADD R3,R1,R2) and mem[1]=0x04 2E 00 0A. Fetch pc=0 then pc=4 back-to-back with out_ready=1.
  -> cycle+1: opcode=0, rs=1, rt=2, rd=3, funct=1.
  -> cycle+2: opcode=1, rs=1, rt=14, imm_signed=10.
  -> out_valid stays high both cycles.
- Sign-extend: mem[2]=0x0507FFFB, fetch pc=8 -> imm_signed=0xFFFFFFFB, jmp_signed=0x0107FFFB.
- Backpressure: fetch pc=0, hold out_ready=0 for 3 cycles with fetch_valid=1 and pc=4.
  -> fetch_ready=0 during the hold.
  -> instr and out_pc=0 stay stable.
  -> after out_ready=1, the next result has out_pc=4.
- Errors:
  -> pc=0x2 gives instr=0, fetch_err=1, out_pc=0x2.
  -> pc=0x100 (ADDR_W=6) gives instr=0, fetch_err=1.
- Load priority/RAW: prog_we=1 to addr 5 with fetch_valid=1 -> fetch_ready=0. A fetch of pc=0x14 on the next cycle returns the new word.
- Flush/reset:
  -> flush while a result is held gives out_valid=0 on the next edge, with no accept that cycle.
  -> rst_n=0 mid-hold gives out_valid=0 and instr=0, and previously loaded mem is still readable after reset.

Source files
------------

// File: rtl/imem_fetch_stage.sv
// imem_fetch_stage: writable instruction memory with a one-cycle registered
// fetch stage and combinational field decode of the returned word.
// Programs are loaded word by word through the prog_* port. Fetches use a
// valid/ready handshake and return their result on the following cycle.
module imem_fetch_stage #(
  parameter int ADDR_W     = 6,
  parameter int REG_ADDR_W = 4,
  parameter int XLEN       = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  prog_we,
  input  logic [ADDR_W-1:0]     prog_addr,
  input  logic [31:0]           prog_data,
  input  logic                  fetch_valid,
  output logic                  fetch_ready,
  input  logic [XLEN-1:0]       pc_in,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       out_pc,
  output logic [31:0]           instr,
  output logic [5:0]            opcode,
  output logic [5:0]            funct,
  output logic [REG_ADDR_W-1:0] rs,
  output logic [REG_ADDR_W-1:0] rt,
  output logic [REG_ADDR_W-1:0] rd,
  output logic [XLEN-1:0]       imm_signed,
  output logic [XLEN-1:0]       jmp_signed,
  output logic                  fetch_err
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [31:0]       mem [DEPTH];
  logic              accept;
  logic              misaligned;
  logic              out_of_range;
  logic [XLEN-3:0]   word_idx;
  logic [ADDR_W-1:0] rd_addr;
  logic [31:0]       fetch_word;
  logic              fetch_bad;

  // Program load port; the array is deliberately left out of reset so a
  // loaded program survives a core reset.
  always_ff @(posedge clk) begin
    if (prog_we) begin
      mem[prog_addr] <= prog_data;
    end
  end

  // A load, a flush or a held result all block new fetches. Because a load
  // blocks the fetch in the same cycle, a read never races a write.
  assign fetch_ready = rst_n & ~prog_we & ~flush & (~out_valid | out_ready);
  assign accept      = fetch_valid & fetch_ready;

  // The pc is a byte address: the low two bits must be zero and the word
  // index must land inside the array, otherwise the fetch returns a NOP.
  assign word_idx     = pc_in[XLEN-1:2];
  assign rd_addr      = pc_in[ADDR_W+1:2];
  assign misaligned   = |pc_in[1:0];
  assign out_of_range = (word_idx >= (XLEN-2)'(DEPTH));
  assign fetch_bad    = misaligned | out_of_range;

  // Select the word to capture, forcing a NOP (all zeros) on a bad address.
  always_comb begin
    fetch_word = 32'h0;
    if (!fetch_bad) begin
      fetch_word = mem[rd_addr];
    end
  end

  // Output stage: flush beats hold, an accept refills the stage, and a
  // consumed result with nothing behind it simply drops valid while the
  // data registers keep their last value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_pc    <= '0;
      instr     <= 32'h0;
      fetch_err <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_pc    <= pc_in;
      instr     <= fetch_word;
      fetch_err <= fetch_bad;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Field decode is pure wiring off the registered instruction, so every
  // field is as stable as instr itself during a hold.
  assign opcode     = instr[31:26];
  assign funct      = instr[5:0];
  assign rs         = instr[21 +: REG_ADDR_W];
  assign rt         = instr[16 +: REG_ADDR_W];
  assign rd         = instr[11 +: REG_ADDR_W];
  assign imm_signed = {{(XLEN-16){instr[15]}}, instr[15:0]};
  assign jmp_signed = {{(XLEN-26){1'b0}}, instr[25:0]};

endmodule

// File: tb/tb_imem_fetch_stage.sv
// tb_imem_fetch_stage: scoreboard bench for imem_fetch_stage. A transaction
// model keeps its own copy of the memory and a queue of outstanding results;
// a monitor compares every DUT output against it on each falling edge.
module tb_imem_fetch_stage;

  localparam int ADDR_W     = 6;
  localparam int REG_ADDR_W = 4;
  localparam int XLEN       = 32;
  localparam int DEPTH      = 64;

  logic                  clk;
  logic                  rst_n;
  logic                  prog_we;
  logic [ADDR_W-1:0]     prog_addr;
  logic [31:0]           prog_data;
  logic                  fetch_valid;
  logic                  fetch_ready;
  logic [XLEN-1:0]       pc_in;
  logic                  flush;
  logic                  out_valid;
  logic                  out_ready;
  logic [XLEN-1:0]       out_pc;
  logic [31:0]           instr;
  logic [5:0]            opcode;
  logic [5:0]            funct;
  logic [REG_ADDR_W-1:0] rs;
  logic [REG_ADDR_W-1:0] rt;
  logic [REG_ADDR_W-1:0] rd;
  logic [XLEN-1:0]       imm_signed;
  logic [XLEN-1:0]       jmp_signed;
  logic                  fetch_err;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
    bit          err;
  } result_t;

  result_t     exp_q[$];
  result_t     last_result;
  logic [31:0] ref_mem [DEPTH];

  imem_fetch_stage #(
    .ADDR_W(ADDR_W),
    .REG_ADDR_W(REG_ADDR_W),
    .XLEN(XLEN)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .prog_we(prog_we),
    .prog_addr(prog_addr),
    .prog_data(prog_data),
    .fetch_valid(fetch_valid),
    .fetch_ready(fetch_ready),
    .pc_in(pc_in),
    .flush(flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_pc(out_pc),
    .instr(instr),
    .opcode(opcode),
    .funct(funct),
    .rs(rs),
    .rt(rt),
    .rd(rd),
    .imm_signed(imm_signed),
    .jmp_signed(jmp_signed),
    .fetch_err(fetch_err)
  );

  // Free-running clock, first rising edge at 5.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  // Expected fetch result from the addressing rules: byte pc, word aligned,
  // word index below the memory depth, otherwise a NOP flagged as an error.
  function automatic result_t predict(input logic [31:0] pc);
    result_t r;
    int      idx;
    r.pc = pc;
    if ((pc % 4) != 0 || (pc / 4) >= 32'(DEPTH)) begin
      r.word = 32'h0;
      r.err  = 1'b1;
    end else begin
      idx    = int'(pc / 4);
      r.word = ref_mem[idx];
      r.err  = 1'b0;
    end
    return r;
  endfunction

  // A new fetch can be taken when running, not loading, not flushing, and
  // the single output slot is either empty or being consumed.
  function automatic bit exp_ready();
    return rst_n && !prog_we && !flush && (exp_q.size() == 0 || out_ready);
  endfunction

  // Transaction model, advanced on every rising edge from the bench inputs.
  initial begin
    bit      acc;
    result_t r;
    last_result = '{pc: 32'h0, word: 32'h0, err: 1'b0};
    forever begin
      @(posedge clk);
      acc = fetch_valid && exp_ready();
      if (!rst_n) begin
        exp_q.delete();
        last_result = '{pc: 32'h0, word: 32'h0, err: 1'b0};
      end else if (flush) begin
        exp_q.delete();
      end else begin
        if (exp_q.size() > 0 && out_ready) begin
          void'(exp_q.pop_front());
        end
        if (acc) begin
          r = predict(pc_in);
          exp_q.push_back(r);
          last_result = r;
        end
      end
      if (prog_we) begin
        ref_mem[prog_addr] = prog_data;
      end
    end
  end

  // Monitor: compare every registered output and decoded field each cycle.
  initial begin
    result_t     cur;
    logic [31:0] w;
    logic [31:0] lo;
    forever begin
      @(negedge clk);
      cur = (exp_q.size() > 0) ? exp_q[0] : last_result;
      w   = cur.word;
      lo  = w % 65536;
      checkOutput("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      checkOutput("out_pc", out_pc, cur.pc);
      checkOutput("instr", instr, w);
      checkOutput("fetch_err", 32'(fetch_err), 32'(cur.err));
      checkOutput("opcode", 32'(opcode), w / 67108864);
      checkOutput("funct", 32'(funct), w % 64);
      checkOutput("rs", 32'(rs), (w / 2097152) % (2 ** REG_ADDR_W));
      checkOutput("rt", 32'(rt), (w / 65536) % (2 ** REG_ADDR_W));
      checkOutput("rd", 32'(rd), (w / 2048) % (2 ** REG_ADDR_W));
      checkOutput("imm_signed", imm_signed, (lo >= 32768) ? lo - 32'd65536 : lo);
      checkOutput("jmp_signed", jmp_signed, w % 67108864);
    end
  end

  // Drive one cycle of inputs on the falling edge, then check fetch_ready.
  task automatic applyStimulus(input bit rst, input bit we, input logic [ADDR_W-1:0] waddr,
                               input logic [31:0] wdata, input bit fv, input logic [31:0] pc,
                               input bit fl, input bit ordy);
    @(negedge clk);
    rst_n       = rst;
    prog_we     = we;
    prog_addr   = waddr;
    prog_data   = wdata;
    fetch_valid = fv;
    pc_in       = pc;
    flush       = fl;
    out_ready   = ordy;
    #1;
    checkOutput("fetch_ready", 32'(fetch_ready), 32'(exp_ready()));
  endtask

  task automatic load(input int addr, input logic [31:0] data);
    applyStimulus(1'b1, 1'b1, ADDR_W'(addr), data, 1'b0, 32'h0, 1'b0, 1'b1);
  endtask

  task automatic fetch(input logic [31:0] pc, input bit ordy);
    applyStimulus(1'b1, 1'b0, '0, 32'h0, 1'b1, pc, 1'b0, ordy);
  endtask

  task automatic idle(input bit ordy);
    applyStimulus(1'b1, 1'b0, '0, 32'h0, 1'b0, 32'h0, 1'b0, ordy);
  endtask

  // Directed scenarios followed by a randomized soak.
  initial begin
    logic [31:0] pc;
    logic [31:0] new_word;
    rst_n       = 1'b0;
    prog_we     = 1'b0;
    prog_addr   = '0;
    prog_data   = 32'h0;
    fetch_valid = 1'b0;
    pc_in       = 32'h0;
    flush       = 1'b0;
    out_ready   = 1'b1;

    applyStimulus(1'b0, 1'b0, '0, 32'h0, 1'b1, 32'h0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, '0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("reset_out_valid", 32'(out_valid), 32'h0);
    checkOutput("reset_instr", instr, 32'h0);
    checkOutput("reset_out_pc", out_pc, 32'h0);

    for (int i = 0; i < DEPTH; i++) begin
      load(i, $urandom);
    end
    load(0, 32'h00221801);
    load(1, 32'h042E000A);
    load(2, 32'h0507FFFB);

    // Back-to-back decode
    fetch(32'h0, 1'b1);
    fetch(32'h4, 1'b1);
    checkOutput("add_rd", 32'(rd), 32'd3);
    checkOutput("add_funct", 32'(funct), 32'd1);
    idle(1'b1);
    checkOutput("i_valid", 32'(out_valid), 32'd1);
    checkOutput("i_rt", 32'(rt), 32'd14);
    checkOutput("i_imm", imm_signed, 32'd10);

    // Sign extension
    fetch(32'h8, 1'b1);
    idle(1'b1);
    checkOutput("sx_imm", imm_signed, 32'hFFFFFFFB);
    checkOutput("sx_jmp", jmp_signed, 32'h0107FFFB);

    // Backpressure
    fetch(32'h0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      fetch(32'h4, 1'b0);
      checkOutput("bp_ready", 32'(fetch_ready), 32'h0);
      checkOutput("bp_out_pc", out_pc, 32'h0);
    end
    fetch(32'h4, 1'b1);
    idle(1'b1);
    checkOutput("bp_next_pc", out_pc, 32'h4);

    // Address errors
    fetch(32'h2, 1'b1);
    idle(1'b1);
    checkOutput("mis_err", 32'(fetch_err), 32'h1);
    checkOutput("mis_pc", out_pc, 32'h2);
    fetch(32'h100, 1'b1);
    idle(1'b1);
    checkOutput("oor_err", 32'(fetch_err), 32'h1);
    checkOutput("oor_instr", instr, 32'h0);

    // Load priority and read-after-write
    new_word = 32'hDEADBEEF;
    applyStimulus(1'b1, 1'b1, 6'd5, new_word, 1'b1, 32'h14, 1'b0, 1'b1);
    checkOutput("load_prio_ready", 32'(fetch_ready), 32'h0);
    fetch(32'h14, 1'b1);
    idle(1'b1);
    checkOutput("raw_instr", instr, new_word);

    // Flush while holding
    fetch(32'h0, 1'b1);
    fetch(32'h4, 1'b0);
    applyStimulus(1'b1, 1'b0, '0, 32'h0, 1'b1, 32'h4, 1'b1, 1'b0);
    idle(1'b0);
    checkOutput("flush_valid", 32'(out_valid), 32'h0);

    // Reset while holding; memory survives
    fetch(32'h8, 1'b1);
    fetch(32'h4, 1'b0);
    applyStimulus(1'b0, 1'b0, '0, 32'h0, 1'b1, 32'h4, 1'b0, 1'b0);
    idle(1'b1);
    checkOutput("rst_hold_valid", 32'(out_valid), 32'h0);
    checkOutput("rst_hold_instr", instr, 32'h0);
    fetch(32'h0, 1'b1);
    idle(1'b1);
    checkOutput("mem_kept", instr, 32'h00221801);

    // Randomized soak
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 9))
        8:       pc = {24'h0, 2'b00, 6'($urandom_range(0, 63))} | 32'($urandom_range(1, 3));
        9:       pc = $urandom;
        default: pc = 32'($urandom_range(0, 63)) * 4;
      endcase
      applyStimulus($urandom_range(0, 49) != 0,
                    $urandom_range(0, 3) == 0,
                    ADDR_W'($urandom_range(0, 63)),
                    $urandom,
                    $urandom_range(0, 3) != 0,
                    pc,
                    $urandom_range(0, 9) == 0,
                    $urandom_range(0, 2) != 0);
    end
    idle(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
